fetch_ctrl: RTL

- Sequencer for the instruction-fetch stage of the RISC pipeline.
- Owns the fetch PC and drives a req/ack instruction-memory port.
- Applies branch redirects (branch_alu & branch_control from EX) and honours hazard stalls.
- Presents a registered IF/ID pair (inst, pc, inst_valid) to decode, plus a flush strobe to kill younger work.

---
 rtl/rv_pkg.sv | 8 +
 rtl/fetch_skid.sv | 31 +++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared widths, constants and fetch FSM state encoding for the fetch stage.
package rv_pkg;
  localparam int unsigned PC_W   = 11;
  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks an acked instruction while IF/ID is stalled.
module fetch_skid
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_inst <= NOP_INST;
      out_pc   <= '0;
      valid    <= 1'b0;
    end else if (clear || unload) begin
      valid <= 1'b0;
    end else if (load) begin
      out_inst <= in_inst;
      out_pc   <= in_pc;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, the imem req/ack port and the IF/ID register.
module fetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP      = NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_alu,
  input  logic              branch_control,
  input  logic [PC_W-1:0]   br_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc,
  output logic              inst_valid,
  output logic              flush
);

  fetch_state_e      state;
  logic [PC_W-1:0]   fetch_pc;
  logic              taken;
  logic              skid_load, skid_unload, skid_clear, skid_valid;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_pc;

  assign taken     = branch_alu & branch_control;
  assign flush     = taken && (state != BOOT);
  assign imem_addr = fetch_pc;

  assign skid_load   = (state == FETCH) && !taken && imem_ack && stall;
  assign skid_unload = (state == HOLD) && !taken && !stall;
  assign skid_clear  = (state == HOLD) && taken;

  fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .in_inst  (imem_rdata),
    .in_pc    (fetch_pc),
    .out_inst (skid_inst),
    .out_pc   (skid_pc),
    .valid    (skid_valid)
  );

  // imem_req is registered alongside the state so it is high exactly in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      inst       <= NOP;
      pc         <= '0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (taken) begin
            fetch_pc   <= br_pc;
            inst       <= NOP;
            inst_valid <= 1'b0;
            // Without an ack the old request is still in flight and must be drained.
            if (!imem_ack) begin
              state    <= DRAIN;
              imem_req <= 1'b0;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 1'b1;
            if (!stall) begin
              inst       <= imem_rdata;
              pc         <= fetch_pc;
              inst_valid <= 1'b1;
            end else begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else if (!stall) begin
            inst       <= NOP;
            inst_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (taken) begin
            fetch_pc   <= br_pc;
            inst       <= NOP;
            inst_valid <= 1'b0;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end else if (!stall) begin
            inst       <= skid_inst;
            pc         <= skid_pc;
            inst_valid <= skid_valid;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end
        end
        DRAIN: begin
          if (taken) begin
            fetch_pc   <= br_pc;
            inst       <= NOP;
            inst_valid <= 1'b0;
          end
          // An ack here retires the stale request even if a new redirect lands this cycle.
          if (imem_ack) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
